sample_capture_buffer: RTL

- Parametrised capture-then-transmit buffer between the ADC serial reader and the Arduino serial writer.
- Collects a run-time-selectable number of ADC samples into a register array, then streams them oldest-first to the writer, one word per start/done handshake.
- Supports one-shot and continuous (auto re-arm) modes, abort, and overrun flagging.

---
 rtl/sample_capture_buffer_if.sv | 33 +++
 rtl/sample_capture_buffer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sample_capture_buffer_if.sv
// Control, ADC-side and writer-side signals of the sample capture buffer.
// master = the surrounding logic that drives commands; slave = the buffer itself.
interface sample_capture_buffer_if #(
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned CNT_W    = 5
);
  logic                arm;
  logic                abort;
  logic                mode;
  logic [CNT_W-1:0]    limit;
  logic                adc_valid;
  logic [SAMPLE_W-1:0] adc_data;
  logic                tx_done;

  logic                tx_start;
  logic [SAMPLE_W-1:0] tx_data;
  logic                busy;
  logic [1:0]          state;
  logic [CNT_W-1:0]    captured;
  logic [CNT_W-1:0]    sent;
  logic                run_done;
  logic                overrun;

  modport master (
    output arm, abort, mode, limit, adc_valid, adc_data, tx_done,
    input  tx_start, tx_data, busy, state, captured, sent, run_done, overrun
  );

  modport slave (
    input  arm, abort, mode, limit, adc_valid, adc_data, tx_done,
    output tx_start, tx_data, busy, state, captured, sent, run_done, overrun
  );
endinterface

// File: rtl/sample_capture_buffer.sv
// Captures a run of ADC samples into a small register array, then streams them
// oldest-first to the serial writer with a one-cycle gap between words.
module sample_capture_buffer #(
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  sample_capture_buffer_if.slave  bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    GAP     = 2'd3
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    lim_q;
  logic [CNT_W-1:0]    captured_q;
  logic [CNT_W-1:0]    sent_q;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic                tx_start_q;
  logic [SAMPLE_W-1:0] tx_data_q;
  logic                busy_q;
  logic                run_done_q;
  logic                overrun_q;

  logic [SAMPLE_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0]    lim_d;
  logic                wr_en_c;
  logic                cap_last_c;
  logic                ack_c;
  logic [SAMPLE_W-1:0] first_word_c;

  // Zero or oversize limits fall back to the full storage depth.
  always_comb begin
    lim_d = bus.limit;
    if (bus.limit == '0 || bus.limit > CNT_W'(DEPTH)) begin
      lim_d = CNT_W'(DEPTH);
    end
  end

  assign wr_en_c    = (state_q == CAPTURE) && bus.adc_valid && !bus.abort;
  assign cap_last_c = wr_en_c && ((captured_q + CNT_W'(1)) == lim_q);
  assign ack_c      = (state_q == DRAIN) && bus.tx_done && tx_start_q && !bus.abort;

  // A one-sample run must forward the word being written this very cycle.
  assign first_word_c = (captured_q == '0) ? bus.adc_data : mem[rd_ptr_q];

  // Storage needs no reset; only words written in the current run are read.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_ptr_q] <= bus.adc_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      lim_q      <= CNT_W'(DEPTH);
      captured_q <= '0;
      sent_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      run_done_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      run_done_q <= 1'b0;
      if (bus.abort) begin
        // Counts stay frozen so software can see how far the run got.
        state_q    <= IDLE;
        tx_start_q <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.arm) begin
              state_q    <= CAPTURE;
              busy_q     <= 1'b1;
              lim_q      <= lim_d;
              captured_q <= '0;
              sent_q     <= '0;
              wr_ptr_q   <= '0;
              rd_ptr_q   <= '0;
              overrun_q  <= 1'b0;
            end
          end
          CAPTURE: begin
            if (wr_en_c) begin
              wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
              captured_q <= captured_q + CNT_W'(1);
              if (cap_last_c) begin
                state_q    <= DRAIN;
                tx_start_q <= 1'b1;
                tx_data_q  <= first_word_c;
              end
            end
          end
          DRAIN: begin
            if (bus.adc_valid) begin
              overrun_q <= 1'b1;
            end
            if (ack_c) begin
              state_q    <= GAP;
              tx_start_q <= 1'b0;
              sent_q     <= sent_q + CNT_W'(1);
              rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
              run_done_q <= ((sent_q + CNT_W'(1)) == lim_q);
            end
          end
          GAP: begin
            if (bus.adc_valid) begin
              overrun_q <= 1'b1;
            end
            if (sent_q != lim_q) begin
              state_q    <= DRAIN;
              tx_start_q <= 1'b1;
              tx_data_q  <= mem[rd_ptr_q];
            end else if (bus.mode) begin
              // Continuous mode re-arms with the same limit; overrun is kept.
              state_q    <= CAPTURE;
              captured_q <= '0;
              sent_q     <= '0;
              wr_ptr_q   <= '0;
              rd_ptr_q   <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign bus.state    = 2'(state_q);
  assign bus.busy     = busy_q;
  assign bus.captured = captured_q;
  assign bus.sent     = sent_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.run_done = run_done_q;
  assign bus.overrun  = overrun_q;

endmodule
